dram_bank_scheduler: RTL and testbench
======================================

Name: dram_bank_scheduler

Overview:
- Parametrised next-generation DRAM command scheduler sitting between the L2 request path and the DRAM command interface.
- Replaces the fixed 8-bank/128-row/2-bit-command control flow with:
  - an open-page policy, with one open-row register per bank;
  - programmable timing waits (tRP, tRCD, tRFC);
  - a parametrised column burst;
  - interval-driven refresh with precharge-all.
- Requests arrive on a valid/ready port. DRAM commands leave one at a time on a req/ack handshake.

Parameters:
- NUM_OF_BANKS, 8, bank count (power of 2, ≥2); BW = $clog2(NUM_OF_BANKS)
- NUM_OF_ROWS, 128, rows per bank (power of 2); RW = $clog2(NUM_OF_ROWS)
- NUM_OF_COLS, 8, columns per row (power of 2); CW = $clog2(NUM_OF_COLS)
- BURST_LEN, 4, column commands per request (1..NUM_OF_COLS)
- T_RP, 2, idle cycles after PRE/PREA ack before next command (≥1)
- T_RCD, 3, idle cycles after ACT ack before first RD/WR (≥1)
- T_RFC, 8, idle cycles after REF ack (≥1)
- REFRESH_INTERVAL, 1024, cycles between refresh requests (>T_RFC+16)

Ports:
- clk  in  1  clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  scheduler accepts request this cycle
- req_rw  in  1  1 = write, 0 = read
- req_bank  in  BW  target bank
- req_row  in  RW  target row
- req_col  in  CW  starting column
- cmd_req  out  1  command valid
- cmd_ack  in  1  DRAM side accepts command
- cmd  out  3  command: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF
- cmd_bank  out  BW  command bank
- cmd_row  out  RW  command row (ACT only; 0 otherwise)
- cmd_col  out  CW  command column (RD/WR only; 0 otherwise)
- busy  out  1  state ≠ IDLE
- refresh_pending  out  1  refresh owed, not yet issued

Behaviour:
- Reset (async, rst_b low):
  - outputs: req_ready=0, cmd_req=0, cmd=0, cmd_bank/row/col=0, busy=0, refresh_pending=0;
  - internal: all bank_open bits = 0; refresh counter = 0; state = IDLE.
  - Outputs become valid on the first clk edge after deassertion; req_ready may rise in that cycle.
  - Reset mid-burst drops the request; no command is completed.
- Command handshake:
  - A command completes on a cycle with cmd_req && cmd_ack.
  - While cmd_req=1 and ack is absent, cmd and all address outputs stay stable.
  - cmd_req drops to 0 in the cycle after completion unless the next command is issued immediately.
- Request handshake:
  - req_ready = (state==IDLE) && !refresh_pending.
  - On req_valid && req_ready, rw/bank/row/col are captured.
- Refresh counter:
  - Counts every cycle. On reaching REFRESH_INTERVAL-1 it wraps to 0 and sets refresh_pending.
  - A second expiry while pending is absorbed: the flag stays 1 and no count is kept.
  - The flag clears when REF completes.
- FSM states: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, BURST, REF_PREA, REF_PREA_WAIT, REF, REF_WAIT.
- IDLE: refresh has priority over requests.
  - If refresh_pending: go to REF_PREA if any bank is open, else REF.
  - Else, on request accept:
    - row hit (bank_open[b] && open_row[b]==row) → BURST;
    - bank open with a different row → PRE;
    - bank closed → ACT.
- PRE: issue PRE to the bank. On ack, clear bank_open[b] and go to PRE_WAIT. PRE_WAIT lasts T_RP cycles, then ACT.
- ACT: issue ACT with bank/row. On ack, set bank_open[b]=1 and open_row[b]=row, then go to ACT_WAIT. ACT_WAIT lasts T_RCD cycles, then BURST.
- BURST:
  - Issues BURST_LEN back-to-back RD or WR commands.
  - Column = (req_col + beat) mod NUM_OF_COLS, i.e. wrap within the row, CW-bit truncation.
  - Beat counter advances only on ack. After the last ack, return to IDLE; the row stays open.
- REF_PREA: issue PREA. On ack, clear all bank_open bits and go to REF_PREA_WAIT. That state lasts T_RP cycles, then REF.
- REF: issue REF. On ack, clear refresh_pending and go to REF_WAIT. REF_WAIT lasts T_RFC cycles, then IDLE.
- A refresh expiry during a request sequence only sets the flag. The current sequence finishes before refresh is serviced.
- Wait counters: width $clog2(max(T_RP,T_RCD,T_RFC)+1). The counter loads on the ack cycle and counts down to 0; the exit happens on the cycle it reads 1.

Decomposition:
- Shared package dram_sched_pkg: 3-bit command encodings (CMD_NOP..CMD_REF) and the FSM state encoding.
- One sub-module, dram_bank_tracker: per-bank open flag and open_row registers. It has set/clear-one and clear-all inputs and a combinational hit/open lookup.
- FSM, beat counter, wait counter and refresh counter live in the top level.

Test Plan:
- Closed-bank read, defaults, bank 2, row 5, col 6: expect ACT(b2,r5), 3 idle cycles, then RD cols 6,7,0,1.
- Row hit: repeat a write to b2, r5, col 0. Expect no ACT; WR cols 0..3 immediately.
- Row miss: read b2, r9. Expect PRE(b2), 2 idle cycles, ACT(b2,r9), 3 idle cycles, RD ×4.
- Ack stall: hold cmd_ack=0 for 5 cycles during beat 2. Expect cmd/cmd_col stable, no extra beats, 4 beats total.
- Refresh with a request present: REFRESH_INTERVAL=64 and a request held valid at expiry. Expect req_ready=0 and refresh_pending=1, then PREA (banks open), 2 idle cycles, REF, 8 idle cycles. Only then is the request accepted, and it takes the ACT path because all banks are closed.
- Async reset mid-ACT_WAIT: expect all outputs 0 immediately. After release, a read to the same bank/row issues ACT because open state was cleared.

Source files
------------

// File: rtl/dram_sched_pkg.sv
// Shared definitions for the DRAM bank scheduler.
//   cmd_e   : 3-bit DRAM command encoding driven on the cmd port
//   state_e : scheduler FSM state encoding
package dram_sched_pkg;

   typedef enum logic [2:0] {
      CMD_NOP  = 3'd0,
      CMD_ACT  = 3'd1,
      CMD_RD   = 3'd2,
      CMD_WR   = 3'd3,
      CMD_PRE  = 3'd4,
      CMD_PREA = 3'd5,
      CMD_REF  = 3'd6
   } cmd_e;

   typedef enum logic [3:0] {
      ST_IDLE          = 4'd0,
      ST_PRE           = 4'd1,
      ST_PRE_WAIT      = 4'd2,
      ST_ACT           = 4'd3,
      ST_ACT_WAIT      = 4'd4,
      ST_BURST         = 4'd5,
      ST_REF_PREA      = 4'd6,
      ST_REF_PREA_WAIT = 4'd7,
      ST_REF           = 4'd8,
      ST_REF_WAIT      = 4'd9
   } state_e;

endpackage

// File: rtl/dram_bank_tracker.sv
// Per-bank open-page state: one open flag and one open-row register per bank.
//   clk, rst_b             : clock / async active-low reset
//   i_set, i_clr, i_bank,
//   i_row                  : open (set) or close (clr) a single bank
//   i_clr_all              : close every bank (precharge-all)
//   i_lk_bank, i_lk_row    : combinational lookup address
//   o_open, o_hit          : looked-up bank is open / open on i_lk_row
//   o_any_open             : at least one bank is open
module dram_bank_tracker #(
   parameter int  NUM_OF_BANKS = 8,
   parameter int  NUM_OF_ROWS  = 128,
   localparam int BW           = $clog2(NUM_OF_BANKS),
   localparam int RW           = $clog2(NUM_OF_ROWS)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          i_set,
   input  logic          i_clr,
   input  logic          i_clr_all,
   input  logic [BW-1:0] i_bank,
   input  logic [RW-1:0] i_row,
   input  logic [BW-1:0] i_lk_bank,
   input  logic [RW-1:0] i_lk_row,
   output logic          o_open,
   output logic          o_hit,
   output logic          o_any_open
);

   logic [NUM_OF_BANKS-1:0]         r_open;
   logic [NUM_OF_BANKS-1:0][RW-1:0] r_row;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_open <= '0;
         r_row  <= '0;
      end else begin
         if (i_clr_all)  r_open         <= '0;
         else if (i_clr) r_open[i_bank] <= 1'b0;
         else if (i_set) r_open[i_bank] <= 1'b1;
         if (i_set) r_row[i_bank] <= i_row;
      end
   end

   assign o_open     = r_open[i_lk_bank];
   assign o_hit      = o_open && (r_row[i_lk_bank] == i_lk_row);
   assign o_any_open = |r_open;

endmodule

// File: rtl/dram_bank_scheduler.sv
// Open-page DRAM command scheduler between the L2 request path and the DRAM
// command interface. Requests are taken on a valid/ready port and turned into
// PRE/ACT/RD/WR sequences; a periodic refresh is serviced with PREA + REF.
//   clk, rst_b                         : clock / async active-low reset
//   req_valid/req_ready                : request handshake
//   req_rw, req_bank, req_row, req_col : request (1 = write), start column
//   cmd_req/cmd_ack                    : command handshake, done on req&&ack
//   cmd, cmd_bank, cmd_row, cmd_col    : command and its address fields
//   busy                               : FSM not idle
//   refresh_pending                    : refresh owed but not yet issued
module dram_bank_scheduler
   import dram_sched_pkg::*;
#(
   parameter int  NUM_OF_BANKS     = 8,
   parameter int  NUM_OF_ROWS      = 128,
   parameter int  NUM_OF_COLS      = 8,
   parameter int  BURST_LEN        = 4,
   parameter int  T_RP             = 2,
   parameter int  T_RCD            = 3,
   parameter int  T_RFC            = 8,
   parameter int  REFRESH_INTERVAL = 1024,
   localparam int BW               = $clog2(NUM_OF_BANKS),
   localparam int RW               = $clog2(NUM_OF_ROWS),
   localparam int CW               = $clog2(NUM_OF_COLS)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_rw,
   input  logic [BW-1:0] req_bank,
   input  logic [RW-1:0] req_row,
   input  logic [CW-1:0] req_col,
   output logic          cmd_req,
   input  logic          cmd_ack,
   output logic [2:0]    cmd,
   output logic [BW-1:0] cmd_bank,
   output logic [RW-1:0] cmd_row,
   output logic [CW-1:0] cmd_col,
   output logic          busy,
   output logic          refresh_pending
);

   localparam int TMAX0 = (T_RP > T_RCD) ? T_RP : T_RCD;
   localparam int TMAX  = (TMAX0 > T_RFC) ? TMAX0 : T_RFC;
   localparam int WW    = $clog2(TMAX + 1);
   localparam int BTW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int RCW   = $clog2(REFRESH_INTERVAL);

   state_e          r_state, w_state_nxt;
   logic            r_rdy_en;
   logic            r_rw;
   logic [BW-1:0]   r_bank;
   logic [RW-1:0]   r_row;
   logic [CW-1:0]   r_col;
   logic [BTW-1:0]  r_beat, w_beat_nxt;
   logic [WW-1:0]   r_wait, w_wait_nxt;
   logic [RCW-1:0]  r_rcnt;
   logic            r_rpend;

   logic            w_req_ready, w_cap, w_set, w_clr, w_clr_all, w_ref_done;
   logic            w_open, w_hit, w_any_open, w_expire;
   cmd_e            w_cmd;
   logic            w_cmd_req;
   logic [BW-1:0]   w_cmd_bank;
   logic [RW-1:0]   w_cmd_row;
   logic [CW-1:0]   w_cmd_col;

   // Lookup uses the live request so the hit/miss/closed decision is made in
   // the same cycle the request is accepted; updates use the captured address.
   dram_bank_tracker #(
      .NUM_OF_BANKS (NUM_OF_BANKS),
      .NUM_OF_ROWS  (NUM_OF_ROWS)
   ) u_tracker (
      .clk        (clk),
      .rst_b      (rst_b),
      .i_set      (w_set),
      .i_clr      (w_clr),
      .i_clr_all  (w_clr_all),
      .i_bank     (r_bank),
      .i_row      (r_row),
      .i_lk_bank  (req_bank),
      .i_lk_row   (req_row),
      .o_open     (w_open),
      .o_hit      (w_hit),
      .o_any_open (w_any_open)
   );

   // r_rdy_en keeps req_ready low until the first edge after reset release.
   assign w_req_ready = r_rdy_en && (r_state == ST_IDLE) && !r_rpend;
   assign w_expire    = (r_rcnt == RCW'(REFRESH_INTERVAL - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      w_beat_nxt  = r_beat;
      w_cap       = 1'b0;
      w_set       = 1'b0;
      w_clr       = 1'b0;
      w_clr_all   = 1'b0;
      w_ref_done  = 1'b0;
      w_cmd       = CMD_NOP;
      w_cmd_req   = 1'b0;
      w_cmd_bank  = '0;
      w_cmd_row   = '0;
      w_cmd_col   = '0;
      case (r_state)
         ST_IDLE: begin
            if (r_rpend) begin
               w_state_nxt = w_any_open ? ST_REF_PREA : ST_REF;
            end else if (req_valid && w_req_ready) begin
               w_cap      = 1'b1;
               w_beat_nxt = '0;
               if (w_hit)       w_state_nxt = ST_BURST;
               else if (w_open) w_state_nxt = ST_PRE;
               else             w_state_nxt = ST_ACT;
            end
         end
         ST_PRE: begin
            w_cmd_req  = 1'b1;
            w_cmd      = CMD_PRE;
            w_cmd_bank = r_bank;
            if (cmd_ack) begin
               w_clr       = 1'b1;
               w_wait_nxt  = WW'(T_RP);
               w_state_nxt = ST_PRE_WAIT;
            end
         end
         ST_PRE_WAIT: begin
            w_wait_nxt = r_wait - WW'(1);
            if (r_wait == WW'(1)) w_state_nxt = ST_ACT;
         end
         ST_ACT: begin
            w_cmd_req  = 1'b1;
            w_cmd      = CMD_ACT;
            w_cmd_bank = r_bank;
            w_cmd_row  = r_row;
            if (cmd_ack) begin
               w_set       = 1'b1;
               w_wait_nxt  = WW'(T_RCD);
               w_state_nxt = ST_ACT_WAIT;
            end
         end
         ST_ACT_WAIT: begin
            w_wait_nxt = r_wait - WW'(1);
            if (r_wait == WW'(1)) w_state_nxt = ST_BURST;
         end
         ST_BURST: begin
            w_cmd_req  = 1'b1;
            w_cmd      = r_rw ? CMD_WR : CMD_RD;
            w_cmd_bank = r_bank;
            // Column wraps inside the row through CW-bit truncation.
            w_cmd_col  = r_col + CW'(r_beat);
            if (cmd_ack) begin
               if (r_beat == BTW'(BURST_LEN - 1)) begin
                  w_beat_nxt  = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_beat_nxt = r_beat + BTW'(1);
               end
            end
         end
         ST_REF_PREA: begin
            w_cmd_req = 1'b1;
            w_cmd     = CMD_PREA;
            if (cmd_ack) begin
               w_clr_all   = 1'b1;
               w_wait_nxt  = WW'(T_RP);
               w_state_nxt = ST_REF_PREA_WAIT;
            end
         end
         ST_REF_PREA_WAIT: begin
            w_wait_nxt = r_wait - WW'(1);
            if (r_wait == WW'(1)) w_state_nxt = ST_REF;
         end
         ST_REF: begin
            w_cmd_req = 1'b1;
            w_cmd     = CMD_REF;
            if (cmd_ack) begin
               w_ref_done  = 1'b1;
               w_wait_nxt  = WW'(T_RFC);
               w_state_nxt = ST_REF_WAIT;
            end
         end
         ST_REF_WAIT: begin
            w_wait_nxt = r_wait - WW'(1);
            if (r_wait == WW'(1)) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state  <= ST_IDLE;
         r_rdy_en <= 1'b0;
         r_rw     <= 1'b0;
         r_bank   <= '0;
         r_row    <= '0;
         r_col    <= '0;
         r_beat   <= '0;
         r_wait   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rdy_en <= 1'b1;
         r_beat   <= w_beat_nxt;
         r_wait   <= w_wait_nxt;
         if (w_cap) begin
            r_rw   <= req_rw;
            r_bank <= req_bank;
            r_row  <= req_row;
            r_col  <= req_col;
         end
      end
   end

   // Free-running refresh timer; an expiry while already pending is absorbed.
   // An expiry coinciding with REF completion re-arms the flag.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_rcnt  <= '0;
         r_rpend <= 1'b0;
      end else begin
         r_rcnt <= w_expire ? '0 : r_rcnt + RCW'(1);
         if (w_expire)        r_rpend <= 1'b1;
         else if (w_ref_done) r_rpend <= 1'b0;
      end
   end

   assign req_ready       = w_req_ready;
   assign cmd_req         = w_cmd_req;
   assign cmd             = w_cmd;
   assign cmd_bank        = w_cmd_bank;
   assign cmd_row         = w_cmd_row;
   assign cmd_col         = w_cmd_col;
   assign busy            = (r_state != ST_IDLE);
   assign refresh_pending = r_rpend;

endmodule

// File: tb/tb_dram_bank_scheduler.sv
// Directed bench for dram_bank_scheduler (defaults, REFRESH_INTERVAL=64).
module tb_dram_bank_scheduler;
   import dram_sched_pkg::*;

   localparam int BW = 3;
   localparam int RW = 7;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_rw = 1'b0;
   logic [BW-1:0] req_bank = '0;
   logic [RW-1:0] req_row = '0;
   logic [CW-1:0] req_col = '0;
   logic          cmd_ack = 1'b0;
   logic          req_ready, cmd_req, busy, refresh_pending;
   logic [2:0]    cmd;
   logic [BW-1:0] cmd_bank;
   logic [RW-1:0] cmd_row;
   logic [CW-1:0] cmd_col;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dram_bank_scheduler #(.REFRESH_INTERVAL(64)) dut (
      .clk             (clk),
      .rst_b           (rst_b),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_rw          (req_rw),
      .req_bank        (req_bank),
      .req_row         (req_row),
      .req_col         (req_col),
      .cmd_req         (cmd_req),
      .cmd_ack         (cmd_ack),
      .cmd             (cmd),
      .cmd_bank        (cmd_bank),
      .cmd_row         (cmd_row),
      .cmd_col         (cmd_col),
      .busy            (busy),
      .refresh_pending (refresh_pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request, wait (bounded) for acceptance, then drop valid.
   task automatic send_req(input string tag, input logic rw, input int b, input int r, input int c);
      int n = 0;
      req_rw = rw; req_bank = BW'(b); req_row = RW'(r); req_col = CW'(c);
      req_valid = 1'b1;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      chk({tag, " ready"}, 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Wait (bounded) for a command, count idle cycles, check it and ack it.
   task automatic expect_cmd(input string tag, input logic [2:0] c, input int b, input int r,
                             input int col, input int exp_idle);
      int idle = 0;
      while (!cmd_req && idle < 100) begin @(negedge clk); idle++; end
      chk({tag, " cmd_req"}, 32'(cmd_req), 32'd1);
      chk({tag, " cmd"}, 32'(cmd), 32'(c));
      chk({tag, " bank"}, 32'(cmd_bank), b);
      chk({tag, " row"}, 32'(cmd_row), r);
      chk({tag, " col"}, 32'(cmd_col), col);
      if (exp_idle >= 0) chk({tag, " idle"}, idle, exp_idle);
      cmd_ack = 1'b1;
      @(negedge clk);
      cmd_ack = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst req_ready", 32'(req_ready), 0);
      chk("rst cmd_req", 32'(cmd_req), 0);
      chk("rst cmd", 32'(cmd), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst pending", 32'(refresh_pending), 0);
      rst_b = 1'b1;
      chk("rel req_ready before edge", 32'(req_ready), 0);
      @(negedge clk);
      chk("rel req_ready after edge", 32'(req_ready), 1);

      // Closed-bank read b2 r5 c6: ACT, 3 idle, RD 6,7,0,1
      send_req("t1", 1'b0, 2, 5, 6);
      chk("t1 busy", 32'(busy), 1);
      expect_cmd("t1 ACT", CMD_ACT, 2, 5, 0, 0);
      expect_cmd("t1 RD0", CMD_RD, 2, 0, 6, 3);
      expect_cmd("t1 RD1", CMD_RD, 2, 0, 7, 0);
      expect_cmd("t1 RD2", CMD_RD, 2, 0, 0, 0);
      expect_cmd("t1 RD3", CMD_RD, 2, 0, 1, 0);
      chk("t1 done cmd_req", 32'(cmd_req), 0);
      chk("t1 done busy", 32'(busy), 0);

      // Row hit write b2 r5 c0: WR 0..3 at once
      send_req("t2", 1'b1, 2, 5, 0);
      expect_cmd("t2 WR0", CMD_WR, 2, 0, 0, 0);
      expect_cmd("t2 WR1", CMD_WR, 2, 0, 1, 0);
      expect_cmd("t2 WR2", CMD_WR, 2, 0, 2, 0);
      expect_cmd("t2 WR3", CMD_WR, 2, 0, 3, 0);

      // Row miss read b2 r9 c3: PRE, 2 idle, ACT, 3 idle, RD 3..6
      send_req("t3", 1'b0, 2, 9, 3);
      expect_cmd("t3 PRE", CMD_PRE, 2, 0, 0, 0);
      expect_cmd("t3 ACT", CMD_ACT, 2, 9, 0, 2);
      expect_cmd("t3 RD0", CMD_RD, 2, 0, 3, 3);
      expect_cmd("t3 RD1", CMD_RD, 2, 0, 4, 0);
      expect_cmd("t3 RD2", CMD_RD, 2, 0, 5, 0);
      expect_cmd("t3 RD3", CMD_RD, 2, 0, 6, 0);

      // Ack stall on beat 2 of a hit read b2 r9 c5 (cols 5,6,7,0)
      send_req("t4", 1'b0, 2, 9, 5);
      expect_cmd("t4 RD0", CMD_RD, 2, 0, 5, 0);
      expect_cmd("t4 RD1", CMD_RD, 2, 0, 6, 0);
      for (int i = 0; i < 5; i++) begin
         chk("t4 stall cmd_req", 32'(cmd_req), 1);
         chk("t4 stall cmd", 32'(cmd), 32'(CMD_RD));
         chk("t4 stall col", 32'(cmd_col), 7);
         @(negedge clk);
      end
      expect_cmd("t4 RD2", CMD_RD, 2, 0, 7, 0);
      expect_cmd("t4 RD3", CMD_RD, 2, 0, 0, 0);
      chk("t4 no extra beat", 32'(cmd_req), 0);
      chk("t4 idle", 32'(busy), 0);

      // Refresh: wait for expiry, then hold a read b5 r1 c2 valid
      begin
         int n = 0;
         while (!refresh_pending && n < 200) begin @(negedge clk); n++; end
      end
      chk("t5 pending", 32'(refresh_pending), 1);
      chk("t5 req_ready", 32'(req_ready), 0);
      req_rw = 1'b0; req_bank = 3'd5; req_row = 7'd1; req_col = 3'd2;
      req_valid = 1'b1;
      expect_cmd("t5 PREA", CMD_PREA, 0, 0, 0, 1);
      chk("t5 prea_wait ready", 32'(req_ready), 0);
      expect_cmd("t5 REF", CMD_REF, 0, 0, 0, 2);
      chk("t5 pending cleared", 32'(refresh_pending), 0);
      chk("t5 ref_wait ready", 32'(req_ready), 0);
      // 8 REF_WAIT cycles + 1 accept cycle; all banks closed -> ACT path
      expect_cmd("t5 ACT", CMD_ACT, 5, 1, 0, 9);
      req_valid = 1'b0;
      expect_cmd("t5 RD0", CMD_RD, 5, 0, 2, 3);
      expect_cmd("t5 RD1", CMD_RD, 5, 0, 3, 0);
      expect_cmd("t5 RD2", CMD_RD, 5, 0, 4, 0);
      expect_cmd("t5 RD3", CMD_RD, 5, 0, 5, 0);

      // Async reset during ACT_WAIT of read b1 r2 c0
      send_req("t6", 1'b0, 1, 2, 0);
      expect_cmd("t6 ACT", CMD_ACT, 1, 2, 0, 0);
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("t6 rst cmd_req", 32'(cmd_req), 0);
      chk("t6 rst cmd", 32'(cmd), 0);
      chk("t6 rst bank", 32'(cmd_bank), 0);
      chk("t6 rst row", 32'(cmd_row), 0);
      chk("t6 rst busy", 32'(busy), 0);
      chk("t6 rst ready", 32'(req_ready), 0);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      send_req("t6b", 1'b0, 1, 2, 0);
      expect_cmd("t6b ACT", CMD_ACT, 1, 2, 0, 0);
      expect_cmd("t6b RD0", CMD_RD, 1, 0, 0, 3);
      expect_cmd("t6b RD1", CMD_RD, 1, 0, 1, 0);
      expect_cmd("t6b RD2", CMD_RD, 1, 0, 2, 0);
      expect_cmd("t6b RD3", CMD_RD, 1, 0, 3, 0);
      chk("t6b done busy", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
